// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - pipeline stage register, optional two-entry skid buffer
// Carries a valid/ready payload with one cycle of latency, plus stall and flush.
module pipe_stage_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
    parameter bit               SKID      = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    input  logic             ready_i,
    input  logic             stall_i,
    input  logic             flush_i,
    output logic [1:0]       occupancy_o
);

    logic             valid_q, valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             accept, xfer_in, xfer_out, ready;

    always_comb begin
        accept   = ready_i & ~stall_i;
        xfer_out = valid_q & accept;
        // skid mode keeps ready a pure flop output; otherwise it looks through to downstream
        ready    = SKID ? ~skid_valid_q : (~valid_q | accept);
        xfer_in  = valid_i & ready;

        valid_d      = valid_q;
        data_d       = data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (flush_i) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            data_d       = FLUSH_VAL;
            skid_data_d  = FLUSH_VAL;
        end else if (SKID) begin
            if (!valid_q || xfer_out) begin
                if (skid_valid_q) begin
                    valid_d      = 1'b1;
                    data_d       = skid_data_q;
                    skid_valid_d = 1'b0;
                end else if (xfer_in) begin
                    valid_d = 1'b1;
                    data_d  = data_i;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (xfer_in) begin
                skid_valid_d = 1'b1;
                skid_data_d  = data_i;
            end
        end else begin
            if (xfer_in) begin
                valid_d = 1'b1;
                data_d  = data_i;
            end else if (xfer_out) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            data_q       <= FLUSH_VAL;
            skid_data_q  <= FLUSH_VAL;
        end else begin
            valid_q      <= valid_d;
            skid_valid_q <= skid_valid_d;
            data_q       <= data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign ready_o     = ready;
    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign occupancy_o = {1'b0, valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg, skid and plain variants
module tb_pipe_stage_reg;

    localparam logic [31:0] FV = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0, ready_i = 1'b0, stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] data_i = '0;

    logic        ready_a, valid_a, ready_b, valid_b;
    logic [31:0] data_a, data_b;
    logic [1:0]  occ_a, occ_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic        hold_a = 1'b0, hold_b = 1'b0;
    logic [31:0] hold_data_a = '0, hold_data_b = '0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(32), .FLUSH_VAL(FV), .SKID(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_a),
        .valid_o(valid_a), .data_o(data_a), .ready_i(ready_i), .stall_i(stall_i),
        .flush_i(flush_i), .occupancy_o(occ_a)
    );

    pipe_stage_reg #(.WIDTH(32), .FLUSH_VAL(FV), .SKID(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .data_i(data_i), .ready_o(ready_b),
        .valid_o(valid_b), .data_o(data_b), .ready_i(ready_i), .stall_i(stall_i),
        .flush_i(flush_i), .occupancy_o(occ_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: pop on transfer-out, flush drops the rest, then record accepted input.
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                chk("stable_valid_a", {31'd0, valid_a}, 32'd1);
                chk("stable_data_a", data_a, hold_data_a);
            end
            if (valid_a && ready_i && !stall_i) begin
                if (q_a.size() == 0) chk("extra_out_a", data_a, 32'hxxxx_xxxx);
                else chk("order_a", data_a, q_a.pop_front());
            end
            if (flush_i) q_a.delete();
            if (valid_i && ready_a && !flush_i) q_a.push_back(data_i);
            hold_a      = valid_a && !(ready_i && !stall_i) && !flush_i;
            hold_data_a = data_a;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q_b.delete();
            hold_b = 1'b0;
        end else begin
            if (hold_b) begin
                chk("stable_valid_b", {31'd0, valid_b}, 32'd1);
                chk("stable_data_b", data_b, hold_data_b);
            end
            if (valid_b && ready_i && !stall_i) begin
                if (q_b.size() == 0) chk("extra_out_b", data_b, 32'hxxxx_xxxx);
                else chk("order_b", data_b, q_b.pop_front());
            end
            if (flush_i) q_b.delete();
            if (valid_i && ready_b && !flush_i) q_b.push_back(data_i);
            hold_b      = valid_b && !(ready_i && !stall_i) && !flush_i;
            hold_data_b = data_b;
        end
    end

    initial begin
        // reset state
        step();
        chk("rst_ready_a", {31'd0, ready_a}, 32'd1);
        chk("rst_ready_b", {31'd0, ready_b}, 32'd1);
        step();
        rst = 1'b0;
        chk("rst_data_a", data_a, FV);
        chk("rst_valid_a", {31'd0, valid_a}, 32'd0);
        chk("rst_occ_a", {30'd0, occ_a}, 32'd0);
        chk("rst_data_b", data_b, FV);

        // stream 1..4 at full rate
        ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            valid_i = 1'b1;
            data_i  = i;
            #1;
            chk("stream_ready_a", {31'd0, ready_a}, 32'd1);
            step();
            chk("stream_data_a", data_a, i);
            chk("stream_valid_a", {31'd0, valid_a}, 32'd1);
            chk("stream_data_b", data_b, i);
        end
        valid_i = 1'b0;
        step();
        chk("stream_drain_a", {31'd0, valid_a}, 32'd0);
        chk("stream_hold_a", data_a, 32'd4);
        step();

        // backpressure A,B into the skid stage
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hA;
        step();
        data_i = 32'hB;
        step();
        valid_i = 1'b0;
        chk("bp_ready_a", {31'd0, ready_a}, 32'd0);
        chk("bp_occ_a", {30'd0, occ_a}, 32'd2);
        chk("bp_data_a", data_a, 32'hA);
        chk("bp_data_b", data_b, 32'hA);
        ready_i = 1'b1;
        step();
        chk("bp_next_a", data_a, 32'hB);
        chk("bp_occ1_a", {30'd0, occ_a}, 32'd1);
        step();
        chk("bp_empty_a", {30'd0, occ_a}, 32'd0);

        // flush with A/B held and C offered
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'hA1;
        step();
        data_i = 32'hB2;
        step();
        chk("fl_pre_occ_a", {30'd0, occ_a}, 32'd2);
        flush_i = 1'b1;
        data_i  = 32'hC3;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("fl_valid_a", {31'd0, valid_a}, 32'd0);
        chk("fl_data_a", data_a, FV);
        chk("fl_occ_a", {30'd0, occ_a}, 32'd0);
        chk("fl_data_b", data_b, FV);
        chk("fl_occ_b", {30'd0, occ_b}, 32'd0);
        ready_i = 1'b1;
        step();
        chk("fl_after_a", {31'd0, valid_a}, 32'd0);

        // stall the plain stage holding 0xDEAD
        valid_i = 1'b1;
        data_i  = 32'hDEAD;
        step();
        valid_i = 1'b0;
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_data_b", data_b, 32'hDEAD);
            chk("st_valid_b", {31'd0, valid_b}, 32'd1);
            chk("st_ready_b", {31'd0, ready_b}, 32'd0);
            step();
        end
        stall_i = 1'b0;
        step();
        chk("st_done_b", {31'd0, valid_b}, 32'd0);
        chk("st_done_a", {31'd0, valid_a}, 32'd0);

        // asynchronous reset mid-operation
        ready_i = 1'b0;
        valid_i = 1'b1;
        data_i  = 32'h55;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("ar_data_a", data_a, FV);
        chk("ar_valid_a", {31'd0, valid_a}, 32'd0);
        chk("ar_occ_a", {30'd0, occ_a}, 32'd0);
        chk("ar_ready_a", {31'd0, ready_a}, 32'd1);
        chk("ar_occ_b", {30'd0, occ_b}, 32'd0);
        step();
        rst     = 1'b0;
        valid_i = 1'b0;
        step();
        chk("ar_post_a", {30'd0, occ_a}, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            valid_i = ($urandom_range(3) != 0);
            ready_i = $urandom_range(1);
            stall_i = ($urandom_range(4) == 0);
            flush_i = ($urandom_range(63) == 0);
            data_i  = $urandom_range(255);
            step();
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        repeat (4) step();
        chk("drain_q_a", q_a.size(), 32'd0);
        chk("drain_q_b", q_b.size(), 32'd0);
        chk("drain_occ_a", {30'd0, occ_a}, 32'd0);
        chk("drain_occ_b", {30'd0, occ_b}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
